// File: rtl/msg_tx_framer_pkg.sv
// Shared constants for the message TX framer: FSM state encodings,
// framing bytes and the checksum step.
package msg_tx_framer_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SOF  = 3'd1;
  localparam logic [2:0] ST_LEN  = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_CSUM = 3'd4;

  localparam logic [7:0] SOF_DEFAULT = 8'h55;
  localparam logic [7:0] KA_REQ      = 8'hAE;
  localparam logic [7:0] KA_RSP      = 8'hEA;

  // Checksum is a plain byte-wise XOR, no carry.
  function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/msg_tx_framer_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo N_SRC.
module msg_tx_framer_rr_arbiter #(
  parameter int N_SRC = 4,
  parameter int IW    = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic [N_SRC-1:0] req,
  input  logic [IW-1:0]    ptr,
  input  logic             enable,
  output logic [IW-1:0]    grant,
  output logic             valid
);

  localparam logic [IW:0] N_W = N_SRC[IW:0];

  logic [IW:0] idx;

  // Scan from ptr upward; the first hit wins and later hits are ignored.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int i = 0; i < N_SRC; i++) begin
      idx = {1'b0, ptr} + i[IW:0];
      if (idx >= N_W) begin
        idx = idx - N_W;
      end else begin
        idx = idx;
      end
      if (enable && !valid && req[idx[IW-1:0]]) begin
        valid = 1'b1;
        grant = idx[IW-1:0];
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/msg_tx_framer.sv
// Round-robin message framer: drains one source at a time and emits
// SOF, LEN, payload[LEN], CSUM on a valid/ready byte stream.
module msg_tx_framer
  import msg_tx_framer_pkg::*;
#(
  parameter int         N_SRC    = 4,
  parameter logic [7:0] SOF_BYTE = SOF_DEFAULT
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic [N_SRC-1:0]   src_have_msg,
  output logic [N_SRC-1:0]   src_rdreq,
  input  logic [8*N_SRC-1:0] src_data,
  input  logic [8*N_SRC-1:0] src_len,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               busy
);

  localparam int            IW       = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_SRC - 1);

  logic [2:0]    state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    len_cnt_q, len_cnt_d;
  logic [7:0]    csum_q, csum_d;

  logic [IW-1:0] arb_grant_s;
  logic          arb_valid_s;
  logic          arb_en_s;
  logic [7:0]    arb_len_s;
  logic [7:0]    cur_data_s;
  logic          fire_s;

  function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] g);
    if (g == LAST_IDX) return '0;
    else               return g + 1'b1;
  endfunction

  // Gating with n_rst keeps a zero-length discard pop from leaking out during reset.
  assign arb_en_s = (state_q == ST_IDLE) && n_rst;

  msg_tx_framer_rr_arbiter #(.N_SRC(N_SRC), .IW(IW)) u_arb (
    .req    (src_have_msg),
    .ptr    (rr_ptr_q),
    .enable (arb_en_s),
    .grant  (arb_grant_s),
    .valid  (arb_valid_s)
  );

  assign arb_len_s  = src_len[{arb_grant_s, 3'b000} +: 8];
  assign cur_data_s = src_data[{grant_q, 3'b000} +: 8];
  assign tx_valid   = (state_q != ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign fire_s     = tx_valid && tx_ready;

  // Next-state, output byte mux and pop strobes.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    len_d     = len_q;
    len_cnt_d = len_cnt_q;
    csum_d    = csum_q;
    tx_data   = 8'h00;
    src_rdreq = '0;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid_s) begin
          grant_d = arb_grant_s;
          len_d   = arb_len_s;
          csum_d  = 8'h00;
          if (arb_len_s != 8'd0) begin
            state_d = ST_SOF;
          end else begin
            src_rdreq[arb_grant_s] = 1'b1;
            rr_ptr_d               = next_ptr(arb_grant_s);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SOF: begin
        tx_data = SOF_BYTE;
        if (fire_s) state_d = ST_LEN;
        else        state_d = ST_SOF;
      end
      ST_LEN: begin
        tx_data = len_q;
        if (fire_s) begin
          csum_d    = csum_step(csum_q, len_q);
          len_cnt_d = len_q;
          state_d   = ST_DATA;
        end else begin
          state_d = ST_LEN;
        end
      end
      ST_DATA: begin
        tx_data = cur_data_s;
        if (fire_s) begin
          src_rdreq[grant_q] = 1'b1;
          csum_d             = csum_step(csum_q, cur_data_s);
          len_cnt_d          = len_cnt_q - 8'd1;
          if (len_cnt_q == 8'd1) state_d = ST_CSUM;
          else                   state_d = ST_DATA;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_CSUM: begin
        tx_data = csum_q;
        if (fire_s) begin
          state_d  = ST_IDLE;
          rr_ptr_d = next_ptr(grant_q);
        end else begin
          state_d = ST_CSUM;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      len_q     <= 8'h00;
      len_cnt_q <= 8'h00;
      csum_q    <= 8'h00;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      len_q     <= len_d;
      len_cnt_q <= len_cnt_d;
      csum_q    <= csum_d;
    end
  end

endmodule

// File: tb/tb_msg_tx_framer.sv
// Directed bench for msg_tx_framer with a small show-ahead source model.
module tb_msg_tx_framer;
  import msg_tx_framer_pkg::*;

  logic        clk   = 1'b0;
  logic        n_rst = 1'b0;
  logic [3:0]  src_have_msg = 4'd0;
  logic [3:0]  src_rdreq;
  logic [31:0] src_data;
  logic [31:0] src_len;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        busy;

  logic [7:0] mem  [4][8];
  logic [7:0] mlen [4];
  logic [3:0] pos  [4];

  int         total = 0;
  int         bad   = 0;
  logic [7:0] txq[$];
  int         rdsrc[$];
  logic [7:0] rdbyte[$];
  int         cyc, first_valid, stall_rd;
  logic       s_valid, s_busy;
  logic [7:0] s_data;
  logic [3:0] s_rd;

  msg_tx_framer #(.N_SRC(4), .SOF_BYTE(8'h55)) dut (
    .clk(clk), .n_rst(n_rst), .src_have_msg(src_have_msg), .src_rdreq(src_rdreq),
    .src_data(src_data), .src_len(src_len), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      src_data[8*i +: 8] = mem[i][pos[i][2:0]];
      src_len[8*i +: 8]  = mlen[i];
    end
  end

  task automatic clear_log();
    txq.delete(); rdsrc.delete(); rdbyte.delete();
    cyc = 0; first_valid = -1; stall_rd = 0;
  endtask

  task automatic reset_all();
    n_rst = 1'b0; tx_ready = 1'b1; src_have_msg = 4'd0;
    for (int i = 0; i < 4; i++) begin
      pos[i] = 4'd0; mlen[i] = 8'd0;
      for (int j = 0; j < 8; j++) mem[i][j] = 8'h00;
    end
    repeat (2) @(posedge clk);
    @(negedge clk); n_rst = 1'b1;
    @(posedge clk); #1;
    clear_log();
  endtask

  task automatic load(input logic [1:0] s, input logic [7:0] l,
                      input logic [7:0] b0, input logic [7:0] b1,
                      input logic [7:0] b2, input logic [7:0] b3);
    mem[s][0] = b0; mem[s][1] = b1; mem[s][2] = b2; mem[s][3] = b3;
    mlen[s] = l; pos[s] = 4'd0; src_have_msg[s] = 1'b1;
  endtask

  // One clock: sample at negedge, then advance sources popped at the posedge.
  task automatic step();
    @(negedge clk);
    s_valid = tx_valid; s_data = tx_data; s_rd = src_rdreq; s_busy = busy;
    if (tx_valid && tx_ready) txq.push_back(tx_data);
    if (tx_valid && first_valid < 0) first_valid = cyc;
    if (tx_valid && !tx_ready && src_rdreq != 4'd0) stall_rd++;
    for (int i = 0; i < 4; i++)
      if (src_rdreq[i]) begin rdsrc.push_back(i); rdbyte.push_back(tx_data); end
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++)
      if (s_rd[i]) begin
        pos[i] = pos[i] + 4'd1;
        if ({4'd0, pos[i]} >= mlen[i]) src_have_msg[i] = 1'b0;
      end
    cyc++;
  endtask

  task automatic test_reset();
    n_rst = 1'b0; #1;
    total++; if (tx_valid !== 1'b0 || busy !== 1'b0 || src_rdreq !== 4'd0 || tx_data !== 8'h00) begin
      bad++; $display("FAIL reset_hold: valid=%b busy=%b rdreq=%b data=%h want 0", tx_valid, busy, src_rdreq, tx_data);
    end
    reset_all();
    step(); step();
    total++; if (s_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", s_valid); end
    total++; if (s_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", s_busy); end
    total++; if (s_rd !== 4'd0) begin bad++; $display("FAIL reset_rdreq: got %b want 0", s_rd); end
    total++; if (s_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", s_data); end
  endtask

  task automatic test_keep_alive();
    logic [7:0] exp_q[$];
    reset_all();
    exp_q = '{8'h55, 8'h01, KA_RSP, 8'hEB};
    load(2'd0, 8'd1, KA_RSP, 8'h00, 8'h00, 8'h00);
    repeat (8) step();
    total++; if (txq.size() != 4) begin bad++; $display("FAIL ka_count: got %0d want 4", txq.size()); end
    for (int i = 0; i < 4; i++) begin
      total++; if (i >= txq.size() || txq[i] !== exp_q[i]) begin
        bad++; $display("FAIL ka_byte%0d: got %h want %h", i, (i < txq.size()) ? txq[i] : 8'hxx, exp_q[i]);
      end
    end
    total++; if (rdsrc.size() != 1 || rdsrc[0] != 0 || rdbyte[0] !== KA_RSP) begin
      bad++; $display("FAIL ka_rdreq: pops=%0d want 1 on src0 coincident with %h", rdsrc.size(), KA_RSP);
    end
    total++; if (first_valid != 1) begin bad++; $display("FAIL ka_latency: got %0d want 1", first_valid); end
    total++; if (s_busy !== 1'b0) begin bad++; $display("FAIL ka_busy_end: got %b want 0", s_busy); end
  endtask

  task automatic test_multi_byte();
    logic [7:0] exp_q[$];
    reset_all();
    exp_q = '{8'h55, 8'h03, 8'h01, 8'h02, 8'h03, 8'h03};
    load(2'd2, 8'd3, 8'h01, 8'h02, 8'h03, 8'h00);
    repeat (10) step();
    total++; if (txq.size() != 6) begin bad++; $display("FAIL mb_count: got %0d want 6", txq.size()); end
    for (int i = 0; i < 6; i++) begin
      total++; if (i >= txq.size() || txq[i] !== exp_q[i]) begin
        bad++; $display("FAIL mb_byte%0d: got %h want %h", i, (i < txq.size()) ? txq[i] : 8'hxx, exp_q[i]);
      end
    end
    total++; if (rdsrc.size() != 3) begin bad++; $display("FAIL mb_pops: got %0d want 3", rdsrc.size()); end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_q[$];
    int         exp_src[$];
    reset_all();
    exp_q = '{8'h55, 8'h01, 8'h11, 8'h10, 8'h55, 8'h01, 8'h22, 8'h23,
              8'h55, 8'h01, 8'h33, 8'h32, 8'h55, 8'h01, 8'h44, 8'h45};
    exp_src = '{0, 1, 0, 1};
    load(2'd0, 8'd1, 8'h11, 8'h00, 8'h00, 8'h00);
    load(2'd1, 8'd1, 8'h22, 8'h00, 8'h00, 8'h00);
    repeat (14) step();
    load(2'd0, 8'd1, 8'h33, 8'h00, 8'h00, 8'h00);
    load(2'd1, 8'd1, 8'h44, 8'h00, 8'h00, 8'h00);
    repeat (14) step();
    total++; if (txq.size() != 16) begin bad++; $display("FAIL rr_count: got %0d want 16", txq.size()); end
    for (int i = 0; i < 16; i++) begin
      total++; if (i >= txq.size() || txq[i] !== exp_q[i]) begin
        bad++; $display("FAIL rr_byte%0d: got %h want %h", i, (i < txq.size()) ? txq[i] : 8'hxx, exp_q[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      total++; if (i >= rdsrc.size() || rdsrc[i] != exp_src[i]) begin
        bad++; $display("FAIL rr_order%0d: got %0d want %0d", i, (i < rdsrc.size()) ? rdsrc[i] : -1, exp_src[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_q[$];
    reset_all();
    exp_q = '{8'h55, 8'h03, 8'hA1, 8'hB2, 8'hC3, 8'hD3};
    load(2'd2, 8'd3, 8'hA1, 8'hB2, 8'hC3, 8'h00);
    repeat (4) step();
    tx_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      total++; if (s_valid !== 1'b1 || s_data !== 8'hB2) begin
        bad++; $display("FAIL bp_hold%0d: valid=%b data=%h want 1/b2", k, s_valid, s_data);
      end
      total++; if (s_rd !== 4'd0) begin bad++; $display("FAIL bp_rdreq%0d: got %b want 0", k, s_rd); end
    end
    tx_ready = 1'b1;
    repeat (8) step();
    total++; if (txq.size() != 6) begin bad++; $display("FAIL bp_count: got %0d want 6", txq.size()); end
    for (int i = 0; i < 6; i++) begin
      total++; if (i >= txq.size() || txq[i] !== exp_q[i]) begin
        bad++; $display("FAIL bp_byte%0d: got %h want %h", i, (i < txq.size()) ? txq[i] : 8'hxx, exp_q[i]);
      end
    end
    total++; if (rdsrc.size() != 3 || stall_rd != 0) begin
      bad++; $display("FAIL bp_pops: got %0d stalled=%0d want 3/0", rdsrc.size(), stall_rd);
    end
  endtask

  task automatic test_zero_length();
    logic [7:0] exp_q[$];
    reset_all();
    load(2'd1, 8'd1, 8'h5A, 8'h00, 8'h00, 8'h00);
    repeat (8) step();
    clear_log();
    load(2'd3, 8'd0, 8'h00, 8'h00, 8'h00, 8'h00);
    repeat (4) step();
    total++; if (rdsrc.size() != 1 || rdsrc[0] != 3) begin
      bad++; $display("FAIL zl_pop: got %0d pops want 1 on src3", rdsrc.size());
    end
    total++; if (first_valid != -1 || txq.size() != 0) begin
      bad++; $display("FAIL zl_novalid: first_valid=%0d bytes=%0d want -1/0", first_valid, txq.size());
    end
    clear_log();
    exp_q = '{8'h55, 8'h01, 8'h10, 8'h11, 8'h55, 8'h01, 8'h20, 8'h21};
    load(2'd0, 8'd1, 8'h10, 8'h00, 8'h00, 8'h00);
    load(2'd2, 8'd1, 8'h20, 8'h00, 8'h00, 8'h00);
    repeat (14) step();
    total++; if (rdsrc.size() < 1 || rdsrc[0] != 0) begin
      bad++; $display("FAIL zl_next: got %0d want 0", (rdsrc.size() > 0) ? rdsrc[0] : -1);
    end
    for (int i = 0; i < 8; i++) begin
      total++; if (i >= txq.size() || txq[i] !== exp_q[i]) begin
        bad++; $display("FAIL zl_byte%0d: got %h want %h", i, (i < txq.size()) ? txq[i] : 8'hxx, exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] exp_q[$];
    reset_all();
    load(2'd1, 8'd4, 8'h01, 8'h02, 8'h03, 8'h04);
    repeat (4) step();
    n_rst = 1'b0; #1;
    total++; if (tx_valid !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0 || src_rdreq !== 4'd0) begin
      bad++; $display("FAIL rmf_async: valid=%b data=%h busy=%b rdreq=%b want 0", tx_valid, tx_data, busy, src_rdreq);
    end
    reset_all();
    exp_q = '{8'h55, 8'h02, 8'h07, 8'h08, 8'h0D};
    load(2'd1, 8'd2, 8'h07, 8'h08, 8'h00, 8'h00);
    repeat (8) step();
    total++; if (txq.size() != 5) begin bad++; $display("FAIL rmf_count: got %0d want 5", txq.size()); end
    for (int i = 0; i < 5; i++) begin
      total++; if (i >= txq.size() || txq[i] !== exp_q[i]) begin
        bad++; $display("FAIL rmf_byte%0d: got %h want %h", i, (i < txq.size()) ? txq[i] : 8'hxx, exp_q[i]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      pos[i] = 4'd0; mlen[i] = 8'd0;
      for (int j = 0; j < 8; j++) mem[i][j] = 8'h00;
    end
    clear_log();
    test_reset();
    test_keep_alive();
    test_multi_byte();
    test_round_robin();
    test_backpressure();
    test_zero_length();
    test_reset_mid_frame();
    total++; if (KA_REQ == KA_RSP) begin bad++; $display("FAIL ka_consts: req=%h rsp=%h", KA_REQ, KA_RSP); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
